// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int KEY_W    = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scan_state_e;

    // Lowest-numbered active-low row wins when several are down.
    function automatic logic [1:0] low_row(input logic [NUM_ROWS-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        priority case (1'b1)
            !rows[0]: idx = 2'd0;
            !rows[1]: idx = 2'd1;
            !rows[2]: idx = 2'd2;
            !rows[3]: idx = 2'd3;
            default:  idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_slot_tick.sv
// Column slot timer: free-running 0..SCAN_DIV-1 counter with a sample strobe
// on the last count of each slot.
module keypad_slot_tick #(
    parameter int SCAN_DIV = 25000
) (
    input  logic clk,
    input  logic rst,
    output logic sample
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign sample = (cnt == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: one-cold column drive, row synchronizer, single-key
// debounce with a one-cycle valid pulse and a held flag until release.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 25000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       row_in,
    output logic [3:0]       col_out,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held
);

    localparam int DW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CNT);

    logic [NUM_ROWS-1:0] row_s1;
    logic [NUM_ROWS-1:0] row_s2;
    logic                sample;

    scan_state_e state, state_n;
    logic [1:0]        col_idx, col_n;
    logic [1:0]        cand_row, cand_row_n;
    logic [1:0]        cand_col, cand_col_n;
    logic [DW-1:0]     dcnt, dcnt_n, dcnt_inc;
    logic [KEY_W-1:0]  key_code_n;
    logic              key_valid_n;
    logic              key_held_n;
    logic              pressed;
    logic [1:0]        hit_row;

    keypad_slot_tick #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .sample(sample)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1 <= '0;
            row_s2 <= '0;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
        end
    end

    assign pressed  = ~&row_s2;
    assign hit_row  = low_row(row_s2);
    assign dcnt_inc = (dcnt == '1) ? dcnt : dcnt + DW'(1);

    always_comb begin
        state_n     = state;
        col_n       = col_idx;
        cand_row_n  = cand_row;
        cand_col_n  = cand_col;
        dcnt_n      = dcnt;
        key_code_n  = key_code;
        key_held_n  = key_held;
        key_valid_n = 1'b0;
        if (sample) begin
            unique case (state)
                SCAN: begin
                    if (pressed) begin
                        cand_row_n = hit_row;
                        cand_col_n = col_idx;
                        dcnt_n     = DW'(1);
                        state_n    = DEBOUNCE;
                    end else begin
                        col_n = col_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (pressed && hit_row == cand_row) begin
                        if (dcnt_inc >= DMAX) begin
                            key_code_n  = {cand_row, cand_col};
                            key_valid_n = 1'b1;
                            key_held_n  = 1'b1;
                            dcnt_n      = '0;
                            state_n     = HELD;
                        end else begin
                            dcnt_n = dcnt_inc;
                        end
                    end else begin
                        dcnt_n  = '0;
                        col_n   = col_idx + 2'd1;
                        state_n = SCAN;
                    end
                end
                HELD: begin
                    // Only the frozen column is driven, so any low row is the held key.
                    if (pressed) begin
                        dcnt_n = '0;
                    end else if (dcnt_inc >= DMAX) begin
                        key_held_n = 1'b0;
                        dcnt_n     = '0;
                        col_n      = col_idx + 2'd1;
                        state_n    = SCAN;
                    end else begin
                        dcnt_n = dcnt_inc;
                    end
                end
                default: begin
                    state_n = SCAN;
                    dcnt_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            col_out   <= 4'b1110;
            cand_row  <= 2'd0;
            cand_col  <= 2'd0;
            dcnt      <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            col_idx   <= col_n;
            col_out   <= col_drive(col_n);
            cand_row  <= cand_row_n;
            cand_col  <= cand_col_n;
            dcnt      <= dcnt_n;
            key_code  <= key_code_n;
            key_valid <= key_valid_n;
            key_held  <= key_held_n;
        end
    end

endmodule
